// File: rtl/multi_dataflow_tcdm_mem_slave_pkg.sv
// Shared types and helpers for the banked TCDM responder.
// Contents:
//   TCDM_DW / TCDM_AW / TCDM_BEW - data, address and byte-enable widths.
//   tcdm_req_t                   - one port's request payload {add, wen, be, data}.
//   tcdm_rsp_t                   - one port's response {r_data, r_valid}.
//   addr_to_bank / addr_to_row   - word-interleaved address decode.
package multi_dataflow_tcdm_mem_package;

    localparam int TCDM_DW  = 32;
    localparam int TCDM_AW  = 32;
    localparam int TCDM_BEW = 4;

    typedef struct packed {
        logic [TCDM_AW-1:0]  add;
        logic                wen;
        logic [TCDM_BEW-1:0] be;
        logic [TCDM_DW-1:0]  data;
    } tcdm_req_t;

    typedef struct packed {
        logic [TCDM_DW-1:0] r_data;
        logic               r_valid;
    } tcdm_rsp_t;

    // Consecutive words go to consecutive banks; nb must be a power of 2.
    function automatic logic [TCDM_AW-1:0] addr_to_bank(input logic [TCDM_AW-1:0] add,
                                                        input int unsigned nb);
        logic [TCDM_AW-1:0] word;
        word = {2'b00, add[TCDM_AW-1:2]};
        return word & (nb - 1);
    endfunction

    // Row inside the bank; upper address bits wrap around.
    function automatic logic [TCDM_AW-1:0] addr_to_row(input logic [TCDM_AW-1:0] add,
                                                       input int unsigned nb,
                                                       input int unsigned rows);
        logic [TCDM_AW-1:0] word;
        word = {2'b00, add[TCDM_AW-1:2]};
        return (word / nb) % rows;
    endfunction

endpackage

// File: rtl/multi_dataflow_tcdm_rr_arbiter.sv
// Combinational round-robin arbiter for one bank.
// Ports:
//   i_req      - request vector, one bit per port
//   i_ptr      - highest-priority port this cycle
//   o_gnt      - one-hot grant (all zero when no request)
//   o_next_ptr - port after the winner, or i_ptr when nothing is granted
module multi_dataflow_tcdm_rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_next_ptr
);

    int   w_idx;
    logic w_found;

    // NOTE: every output and temporary gets a default before the loop, so
    // no path through this block leaves a value unassigned (no latch).
    always_comb begin
        o_gnt      = '0;
        o_next_ptr = i_ptr;
        w_found    = 1'b0;
        w_idx      = 0;
        // Scan upward from the pointer, wrapping modulo N; first hit wins.
        for (int k = 0; k < N; k++) begin
            w_idx = int'(i_ptr) + k;
            if (w_idx >= N) w_idx = w_idx - N;
            if (!w_found && i_req[w_idx]) begin
                w_found       = 1'b1;
                o_gnt[w_idx]  = 1'b1;
                o_next_ptr    = (w_idx == N - 1) ? '0 : PW'(w_idx + 1);
            end
        end
    end

endmodule

// File: rtl/multi_dataflow_tcdm_mem_slave.sv
// Multi-port banked TCDM responder (memory side of HWPE TCDM master ports).
// Ports:
//   clk_i, rst_i   - clock, synchronous active-high reset
//   tcdm_req       - per-port request
//   tcdm_gnt       - per-port grant, combinational in the request cycle
//   tcdm_add       - per-port byte address (MP x 32, port p at [32p +: 32])
//   tcdm_wen       - per-port 1 = read, 0 = write
//   tcdm_be        - per-port byte enables (MP x 4)
//   tcdm_data      - per-port write data (MP x 32)
//   tcdm_r_data    - per-port read data, valid with r_valid (MP x 32)
//   tcdm_r_valid   - per-port response strobe, one cycle after grant
module multi_dataflow_tcdm_mem_slave
    import multi_dataflow_tcdm_mem_package::*;
#(
    parameter int          MP        = 2,
    parameter int          NB        = 4,
    parameter int          BANK_ROWS = 256,
    parameter int          STALL_EN  = 0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [MP-1:0]         tcdm_req,
    output logic [MP-1:0]         tcdm_gnt,
    input  logic [MP*TCDM_AW-1:0] tcdm_add,
    input  logic [MP-1:0]         tcdm_wen,
    input  logic [MP*TCDM_BEW-1:0] tcdm_be,
    input  logic [MP*TCDM_DW-1:0] tcdm_data,
    output logic [MP*TCDM_DW-1:0] tcdm_r_data,
    output logic [MP-1:0]         tcdm_r_valid
);

    localparam int PW = (MP > 1) ? $clog2(MP) : 1;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int RW = (BANK_ROWS > 1) ? $clog2(BANK_ROWS) : 1;

    tcdm_req_t          w_req  [MP];
    logic [BW-1:0]      w_bank [MP];
    logic [RW-1:0]      w_row  [MP];

    always_comb begin
        for (int p = 0; p < MP; p++) begin
            w_req[p].add  = tcdm_add[p*TCDM_AW +: TCDM_AW];
            w_req[p].wen  = tcdm_wen[p];
            w_req[p].be   = tcdm_be[p*TCDM_BEW +: TCDM_BEW];
            w_req[p].data = tcdm_data[p*TCDM_DW +: TCDM_DW];
            w_bank[p]     = BW'(addr_to_bank(w_req[p].add, NB));
            w_row[p]      = RW'(addr_to_row(w_req[p].add, NB, BANK_ROWS));
        end
    end

    // Grant-gating LFSR, x^16+x^14+x^13+x^11+1 in Fibonacci form.
    logic [15:0] r_lfsr;
    logic        w_stall;
    logic        w_go;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_lfsr <= LFSR_SEED;
        else       r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
    end

    assign w_stall = (STALL_EN != 0) && (r_lfsr[1:0] == 2'b00);
    // Masking requests (rather than grants) keeps the pointers frozen too.
    assign w_go    = !w_stall && !rst_i;

    logic [MP-1:0]      w_bank_req   [NB];
    logic [MP-1:0]      w_bank_gnt   [NB];
    logic [PW-1:0]      r_rr_ptr     [NB];
    logic [PW-1:0]      w_next_ptr   [NB];
    logic [TCDM_DW-1:0] w_bank_rdata [NB];

    always_comb begin
        for (int b = 0; b < NB; b++)
            for (int p = 0; p < MP; p++)
                w_bank_req[b][p] = tcdm_req[p] && (w_bank[p] == BW'(b)) && w_go;
    end

    for (genvar b = 0; b < NB; b++) begin : g_bank
        logic [PW-1:0]      w_win_port;
        logic               w_win_valid;
        tcdm_req_t          w_win_req;
        logic [RW-1:0]      w_win_row;
        logic [TCDM_DW-1:0] r_mem [BANK_ROWS];
        logic [TCDM_DW-1:0] r_rdata;

        multi_dataflow_tcdm_rr_arbiter #(.N(MP), .PW(PW)) u_arb (
            .i_req      (w_bank_req[b]),
            .i_ptr      (r_rr_ptr[b]),
            .o_gnt      (w_bank_gnt[b]),
            .o_next_ptr (w_next_ptr[b])
        );

        always_ff @(posedge clk_i) begin
            if (rst_i)                r_rr_ptr[b] <= '0;
            else if (|w_bank_gnt[b])  r_rr_ptr[b] <= w_next_ptr[b];
        end

        always_comb begin
            w_win_port = '0;
            for (int p = 0; p < MP; p++)
                if (w_bank_gnt[b][p]) w_win_port = PW'(p);
        end

        assign w_win_valid = |w_bank_gnt[b];
        assign w_win_req   = w_req[w_win_port];
        assign w_win_row   = w_row[w_win_port];

        // NOTE: the SRAM array and its read register have no reset branch;
        // memory contents survive rst_i, and resetting them would not map to SRAM.
        always_ff @(posedge clk_i) begin
            if (w_win_valid) begin
                if (w_win_req.wen) begin
                    r_rdata <= r_mem[w_win_row];
                end else begin
                    for (int i = 0; i < TCDM_BEW; i++)
                        if (w_win_req.be[i])
                            r_mem[w_win_row][8*i +: 8] <= w_win_req.data[8*i +: 8];
                end
            end
        end

        assign w_bank_rdata[b] = r_rdata;
    end

    // A port wins at most one bank, so OR-ing per-bank grants is exact.
    always_comb begin
        tcdm_gnt = '0;
        for (int b = 0; b < NB; b++)
            tcdm_gnt = tcdm_gnt | w_bank_gnt[b];
    end

    // Response tracking: which bank to pull read data from one cycle later.
    logic [MP-1:0] r_valid;
    logic [MP-1:0] r_is_read;
    logic [BW-1:0] r_src_bank [MP];
    tcdm_rsp_t     w_rsp      [MP];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid   <= '0;
            r_is_read <= '0;
            for (int p = 0; p < MP; p++) r_src_bank[p] <= '0;
        end else begin
            r_valid   <= tcdm_gnt;
            r_is_read <= tcdm_gnt & tcdm_wen;
            for (int p = 0; p < MP; p++) r_src_bank[p] <= w_bank[p];
        end
    end

    always_comb begin
        for (int p = 0; p < MP; p++) begin
            w_rsp[p].r_valid = r_valid[p];
            w_rsp[p].r_data  = r_is_read[p] ? w_bank_rdata[r_src_bank[p]] : '0;
            tcdm_r_valid[p]                  = w_rsp[p].r_valid;
            tcdm_r_data[p*TCDM_DW +: TCDM_DW] = w_rsp[p].r_data;
        end
    end

endmodule

// File: tb/tb_multi_dataflow_tcdm_mem_slave.sv
// Self-checking bench for multi_dataflow_tcdm_mem_slave (MP=2, NB=4, 256 rows).
// Reference model: flat word memory indexed by word address mod (NB*BANK_ROWS),
// per-bank next-priority port, and an LFSR sequence for the stalling instance.
module tb_multi_dataflow_tcdm_mem_slave;

    localparam int MP    = 2;
    localparam int NB    = 4;
    localparam int ROWS  = 256;
    localparam int WORDS = NB * ROWS;

    logic        clk_i;
    logic        rst_i;
    logic [1:0]  tcdm_req,  s_req;
    logic [1:0]  tcdm_gnt,  s_gnt;
    logic [63:0] tcdm_add,  s_add;
    logic [1:0]  tcdm_wen,  s_wen;
    logic [7:0]  tcdm_be,   s_be;
    logic [63:0] tcdm_data, s_data;
    logic [63:0] tcdm_r_data, s_r_data;
    logic [1:0]  tcdm_r_valid, s_r_valid;

    multi_dataflow_tcdm_mem_slave #(.MP(MP), .NB(NB), .BANK_ROWS(ROWS), .STALL_EN(0)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .tcdm_req(tcdm_req), .tcdm_gnt(tcdm_gnt), .tcdm_add(tcdm_add),
        .tcdm_wen(tcdm_wen), .tcdm_be(tcdm_be), .tcdm_data(tcdm_data),
        .tcdm_r_data(tcdm_r_data), .tcdm_r_valid(tcdm_r_valid)
    );

    multi_dataflow_tcdm_mem_slave #(.MP(MP), .NB(NB), .BANK_ROWS(ROWS), .STALL_EN(1),
                                    .LFSR_SEED(16'hACE1)) dut_s (
        .clk_i(clk_i), .rst_i(rst_i),
        .tcdm_req(s_req), .tcdm_gnt(s_gnt), .tcdm_add(s_add),
        .tcdm_wen(s_wen), .tcdm_be(s_be), .tcdm_data(s_data),
        .tcdm_r_data(s_r_data), .tcdm_r_valid(s_r_valid)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mm [WORDS];
    int          prio [NB];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % WORDS);
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    // One bus cycle on the main instance; called at a falling edge.
    task automatic step(input logic [1:0] rq, input logic [31:0] a0, input logic [31:0] a1,
                        input logic [1:0] we, input logic [3:0] b0, input logic [3:0] b1,
                        input logic [31:0] d0, input logic [31:0] d1);
        logic [31:0] a [2];
        logic [3:0]  b [2];
        logic [31:0] d [2];
        logic [1:0]  eg;
        logic [1:0]  nv;
        logic [31:0] nd [2];
        a[0] = a0; a[1] = a1; b[0] = b0; b[1] = b1; d[0] = d0; d[1] = d1;
        tcdm_req = rq; tcdm_add = {a1, a0}; tcdm_wen = we;
        tcdm_be = {b1, b0}; tcdm_data = {d1, d0};
        eg = '0;
        for (int bk = 0; bk < NB; bk++) begin
            bit taken = 1'b0;
            for (int k = 0; k < MP; k++) begin
                int p = (prio[bk] + k) % MP;
                if (!taken && rq[p] && (widx(a[p]) % NB) == bk) begin
                    taken    = 1'b1;
                    eg[p]    = 1'b1;
                    prio[bk] = (p + 1) % MP;
                end
            end
        end
        #1;
        chk("gnt", {30'd0, tcdm_gnt}, {30'd0, eg});
        nv = eg;
        for (int p = 0; p < MP; p++) nd[p] = (eg[p] && we[p]) ? mm[widx(a[p])] : 32'h0;
        for (int p = 0; p < MP; p++)
            if (eg[p] && !we[p])
                for (int i = 0; i < 4; i++)
                    if (b[p][i]) mm[widx(a[p])][8*i +: 8] = d[p][8*i +: 8];
        @(posedge clk_i); #1;
        for (int p = 0; p < MP; p++) begin
            chk($sformatf("r_valid%0d", p), {31'd0, tcdm_r_valid[p]}, {31'd0, nv[p]});
            if (nv[p]) chk($sformatf("r_data%0d", p), tcdm_r_data[p*32 +: 32], nd[p]);
        end
        tcdm_req = '0;
        @(negedge clk_i);
    endtask

    initial begin
        logic [15:0] lf;
        int          stalls;
        logic [1:0]  prev_g;
        logic [1:0]  exp_g;

        rst_i = 1'b1;
        tcdm_req = 2'b11; tcdm_add = '0; tcdm_wen = 2'b11; tcdm_be = '0; tcdm_data = '0;
        s_req = '0; s_add = {32'h4, 32'h0}; s_wen = 2'b11; s_be = '0; s_data = '0;
        for (int bk = 0; bk < NB; bk++) prio[bk] = 0;

        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_gnt",    {30'd0, tcdm_gnt},     32'h0);
        chk("rst_rvalid", {30'd0, tcdm_r_valid}, 32'h0);
        chk("rst_rdata0", tcdm_r_data[31:0],     32'h0);
        chk("rst_rdata1", tcdm_r_data[63:32],    32'h0);
        @(negedge clk_i);
        rst_i = 1'b0; tcdm_req = '0;

        // Single port write then read.
        step(2'b01, 32'h0, 32'h0, 2'b00, 4'hF, 4'h0, 32'hDEADBEEF, 32'h0);
        step(2'b01, 32'h0, 32'h0, 2'b01, 4'h0, 4'h0, 32'h0, 32'h0);

        // Partial byte enables.
        step(2'b01, 32'h20, 32'h0, 2'b00, 4'hF, 4'h0, 32'h11223344, 32'h0);
        step(2'b01, 32'h20, 32'h0, 2'b00, 4'b0101, 4'h0, 32'hAABBCCDD, 32'h0);
        step(2'b01, 32'h20, 32'h0, 2'b01, 4'h0, 4'h0, 32'h0, 32'h0);
        chk("be_merge", mm[8], 32'h11BB33DD);

        // Bank conflict: p1 preloads 0x10, then both ports hammer it.
        step(2'b10, 32'h0, 32'h10, 2'b00, 4'h0, 4'hF, 32'h0, 32'hC0FFEE01);
        for (int i = 0; i < 4; i++) begin
            step(2'b11, 32'h10, 32'h10, 2'b11, 4'h0, 4'h0, 32'h0, 32'h0);
        end

        // Distinct banks served together.
        step(2'b10, 32'h0, 32'h4, 2'b00, 4'h0, 4'hF, 32'h0, 32'h13579BDF);
        step(2'b11, 32'h0, 32'h4, 2'b11, 4'h0, 4'h0, 32'h0, 32'h0);

        // Address wrap: 0x1000 aliases 0x0.
        step(2'b01, 32'h1000, 32'h0, 2'b00, 4'hF, 4'h0, 32'h5A5A1234, 32'h0);
        step(2'b10, 32'h0, 32'h0, 2'b11, 4'h0, 4'h0, 32'h0, 32'h0);

        // Randomized traffic over a preloaded window (with wrapped aliases).
        for (int w = 0; w < 32; w++)
            step(2'b01, 32'(w * 4), 32'h0, 2'b00, 4'hF, 4'h0, $urandom, 32'h0);
        for (int i = 0; i < 300; i++) begin
            logic [31:0] ra0, ra1;
            ra0 = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3))
                  | (32'($urandom_range(0, 3)) << 12);
            ra1 = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3))
                  | (32'($urandom_range(0, 3)) << 12);
            step(2'($urandom), ra0, ra1, 2'($urandom), 4'($urandom), 4'($urandom),
                 $urandom, $urandom);
        end

        // Reset while a read would be granted; pointer must come back to 0.
        step(2'b01, 32'h0, 32'h0, 2'b01, 4'h0, 4'h0, 32'h0, 32'h0);
        tcdm_req = 2'b11; tcdm_add = {32'h0, 32'h0}; tcdm_wen = 2'b11;
        rst_i = 1'b1;
        #1;
        chk("rst_mid_gnt", {30'd0, tcdm_gnt}, 32'h0);
        @(posedge clk_i); #1;
        chk("rst_mid_rvalid", {30'd0, tcdm_r_valid}, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int bk = 0; bk < NB; bk++) prio[bk] = 0;
        step(2'b11, 32'h0, 32'h0, 2'b11, 4'h0, 4'h0, 32'h0, 32'h0);

        // Stalling instance: constant requests to two banks.
        rst_i = 1'b1; s_req = 2'b11;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int bk = 0; bk < NB; bk++) prio[bk] = 0;
        lf = 16'hACE1; stalls = 0; prev_g = 2'b00;
        for (int i = 0; i < 400; i++) begin
            #1;
            exp_g = (lf[1:0] == 2'b00) ? 2'b00 : 2'b11;
            if (exp_g == 2'b00) stalls++;
            chk("stall_gnt", {30'd0, s_gnt}, {30'd0, exp_g});
            @(posedge clk_i); #1;
            chk("stall_rvalid", {30'd0, s_r_valid}, {30'd0, exp_g});
            lf = lfsr_next(lf);
            prev_g = exp_g;
            @(negedge clk_i);
        end
        chk("stall_rate", {31'd0, (stalls >= 60 && stalls <= 140)}, 32'h1);
        s_req = '0;
        if (prev_g != 2'b00) @(posedge clk_i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
